// File: rtl/apb_initiator.sv
// APB initiator: turns a valid/ready command into one APB transfer
// (SETUP then ACCESS) with a bounded wait-state timeout and a one-cycle
// completion pulse. All outputs come straight from flops.
module apb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_PCLK,
    input  logic        i_PRESET,
    input  logic        i_CMD_VALID,
    output logic        o_CMD_READY,
    input  logic        i_CMD_WRITE,
    input  logic [15:0] i_CMD_ADDR,
    input  logic [7:0]  i_CMD_WDATA,
    output logic        o_PSEL0,
    output logic        o_PENABLE,
    output logic        o_PWRITE,
    output logic [15:0] o_PADDR,
    output logic [7:0]  o_PWDATA,
    input  logic [7:0]  i_PRDATA,
    input  logic        i_PREADY,
    output logic        o_RSP_VALID,
    output logic [7:0]  o_RSP_RDATA,
    output logic        o_RSP_TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Counter value seen on the last ACCESS cycle that may still wait.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  wait_cnt_q;
    logic [7:0]  wait_cnt_d;
    logic        cmd_ready_q;
    logic        psel_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [15:0] paddr_q;
    logic [7:0]  pwdata_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_timeout_q;

    // Incremented wait count, used when ACCESS keeps waiting.
    always_comb begin
        wait_cnt_d = wait_cnt_q + 8'd1;
    end

    // Transfer sequencer with all outputs registered alongside the state.
    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 8'd0;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 16'h0000;
            pwdata_q      <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // cmd_ready_q is low only on the first edge after reset.
                    if (cmd_ready_q && i_CMD_VALID) begin
                        state_q     <= ST_SETUP;
                        cmd_ready_q <= 1'b0;
                        wait_cnt_q  <= 8'd0;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        pwrite_q    <= i_CMD_WRITE;
                        paddr_q     <= i_CMD_ADDR;
                        pwdata_q    <= i_CMD_WRITE ? i_CMD_WDATA : 8'h00;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    // Ready wins over timeout on the same edge.
                    if (i_PREADY) begin
                        state_q       <= ST_IDLE;
                        cmd_ready_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= pwrite_q ? 8'h00 : i_PRDATA;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q       <= ST_IDLE;
                        cmd_ready_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= 8'h00;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    wait_cnt_q  <= 8'd0;
                end
            endcase
        end
    end

    assign o_CMD_READY   = cmd_ready_q;
    assign o_PSEL0       = psel_q;
    assign o_PENABLE     = penable_q;
    assign o_PWRITE      = pwrite_q;
    assign o_PADDR       = paddr_q;
    assign o_PWDATA      = pwdata_q;
    assign o_RSP_VALID   = rsp_valid_q;
    assign o_RSP_RDATA   = rsp_rdata_q;
    assign o_RSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: transaction-level model compared
// every cycle, plus hand-computed checks per directed scenario.
module tb_apb_initiator;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_CMD_VALID = 1'b0;
    logic        i_CMD_WRITE = 1'b0;
    logic [15:0] i_CMD_ADDR = 16'h0000;
    logic [7:0]  i_CMD_WDATA = 8'h00;
    logic [7:0]  i_PRDATA = 8'h00;
    logic        i_PREADY = 1'b0;
    logic        o_CMD_READY, o_PSEL0, o_PENABLE, o_PWRITE;
    logic [15:0] o_PADDR;
    logic [7:0]  o_PWDATA, o_RSP_RDATA;
    logic        o_RSP_VALID, o_RSP_TIMEOUT;

    apb_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .i_PCLK(clk), .i_PRESET(rst),
        .i_CMD_VALID(i_CMD_VALID), .o_CMD_READY(o_CMD_READY),
        .i_CMD_WRITE(i_CMD_WRITE), .i_CMD_ADDR(i_CMD_ADDR), .i_CMD_WDATA(i_CMD_WDATA),
        .o_PSEL0(o_PSEL0), .o_PENABLE(o_PENABLE), .o_PWRITE(o_PWRITE),
        .o_PADDR(o_PADDR), .o_PWDATA(o_PWDATA),
        .i_PRDATA(i_PRDATA), .i_PREADY(i_PREADY),
        .o_RSP_VALID(o_RSP_VALID), .o_RSP_RDATA(o_RSP_RDATA), .o_RSP_TIMEOUT(o_RSP_TIMEOUT)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_xfer: 0 = no transfer, 1 = setup cycle, n>=2 = ACCESS cycle number n-1
    int          m_xfer;
    logic        m_ready, m_pwrite, m_rsp_valid, m_tmo;
    logic [15:0] m_paddr;
    logic [7:0]  m_pwdata, m_rdata;

    // Model: predicts the outputs after every edge from the inputs seen at it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_xfer <= 0; m_ready <= 1'b0; m_pwrite <= 1'b0; m_paddr <= 16'h0000;
            m_pwdata <= 8'h00; m_rsp_valid <= 1'b0; m_tmo <= 1'b0; m_rdata <= 8'h00;
        end else begin
            m_rsp_valid <= 1'b0;
            if (m_xfer == 0) begin
                if (m_ready && i_CMD_VALID) begin
                    m_xfer <= 1; m_ready <= 1'b0;
                    m_paddr <= i_CMD_ADDR; m_pwrite <= i_CMD_WRITE;
                    m_pwdata <= i_CMD_WRITE ? i_CMD_WDATA : 8'h00;
                end else begin
                    m_ready <= 1'b1;
                end
            end else if (m_xfer >= 2 && (i_PREADY || (m_xfer - 1) == T)) begin
                m_xfer <= 0; m_ready <= 1'b1; m_rsp_valid <= 1'b1;
                m_tmo <= !i_PREADY;
                m_rdata <= (i_PREADY && !m_pwrite) ? i_PRDATA : 8'h00;
            end else begin
                m_xfer <= m_xfer + 1;
            end
        end
    end

    // Compare: every output against the model on each falling edge.
    always @(negedge clk) begin
        chk("cmd_ready", o_CMD_READY, m_ready);
        chk("psel", o_PSEL0, m_xfer != 0);
        chk("penable", o_PENABLE, m_xfer >= 2);
        chk("pwrite", o_PWRITE, m_pwrite);
        chk("paddr", o_PADDR, m_paddr);
        chk("pwdata", o_PWDATA, m_pwdata);
        chk("rsp_valid", o_RSP_VALID, m_rsp_valid);
        chk("rsp_rdata", o_RSP_RDATA, m_rdata);
        chk("rsp_timeout", o_RSP_TIMEOUT, m_tmo);
    end

    // ---------------- completer emulation and monitors ----------------
    int         waits = 0;      // wait states before PREADY (255 = never)
    logic [7:0] prdata_v = 8'h00;
    int         acc_k = 0, last_acc = 0, rsp_count = 0;
    logic [7:0] last_rdata = 8'h00;
    logic       last_tmo = 1'b0;
    int         cyc = 0, acc_n = 0;
    int         acc_times [16];

    // Completer: PREADY/PRDATA per ACCESS cycle, counts ACCESS length, logs responses.
    always @(negedge clk) begin
        if (o_PSEL0 && o_PENABLE) begin
            acc_k    <= acc_k + 1;
            i_PREADY <= (acc_k + 1 > waits);
            i_PRDATA <= prdata_v;
        end else begin
            if (acc_k != 0) last_acc <= acc_k;
            acc_k    <= 0;
            i_PREADY <= 1'b1;
            i_PRDATA <= 8'hEE;
        end
        if (o_RSP_VALID) begin
            rsp_count  <= rsp_count + 1;
            last_rdata <= o_RSP_RDATA;
            last_tmo   <= o_RSP_TIMEOUT;
        end
    end

    // Accept log: cycle number of every command handshake.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && o_CMD_READY && i_CMD_VALID) begin
            acc_times[acc_n % 16] <= cyc;
            acc_n <= acc_n + 1;
        end
    end

    // Present a command (at a falling edge) and return one falling edge after acceptance.
    task automatic send(input logic wr, input logic [15:0] a, input logic [7:0] d);
        bit ok = 1'b0;
        i_CMD_VALID = 1'b1; i_CMD_WRITE = wr; i_CMD_ADDR = a; i_CMD_WDATA = d;
        for (int n = 0; n < 100; n++) begin
            if (o_CMD_READY) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("accept_timeout", ok, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_rsp(input int target);
        bit ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rsp_count >= target) begin ok = 1'b1; break; end
        end
        chk("rsp_wait_timeout", ok, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, n0;
        bit found;
        // Reset state and first edge after release
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", o_CMD_READY, 1'b0);
        chk("reset_psel", o_PSEL0, 1'b0);
        chk("reset_paddr", o_PADDR, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", o_CMD_READY, 1'b1);

        // Zero-wait write
        waits = 0; r0 = rsp_count;
        send(1'b1, 16'h0104, 8'hA5);
        i_CMD_VALID = 1'b0;
        wait_rsp(r0 + 1);
        chk("wr_access_cycles", last_acc, 1);
        chk("wr_rdata", last_rdata, 8'h00);
        chk("wr_timeout", last_tmo, 1'b0);
        chk("wr_paddr_hold", o_PADDR, 16'h0104);
        chk("wr_pwdata_hold", o_PWDATA, 8'hA5);

        // Read with three wait states
        waits = 3; prdata_v = 8'h3C; r0 = rsp_count;
        send(1'b0, 16'h0108, 8'h77);
        i_CMD_VALID = 1'b0;
        wait_rsp(r0 + 1);
        chk("rd_access_cycles", last_acc, 4);
        chk("rd_rdata", last_rdata, 8'h3C);
        chk("rd_timeout", last_tmo, 1'b0);
        chk("rd_pwdata", o_PWDATA, 8'h00);

        // Timeout: PREADY never rises
        waits = 255; prdata_v = 8'h99; r0 = rsp_count;
        send(1'b0, 16'h0110, 8'h00);
        i_CMD_VALID = 1'b0;
        wait_rsp(r0 + 1);
        chk("tmo_access_cycles", last_acc, 16);
        chk("tmo_flag", last_tmo, 1'b1);
        chk("tmo_rdata", last_rdata, 8'h00);

        // PREADY in the last permitted ACCESS cycle completes normally
        waits = 15; prdata_v = 8'h5A; r0 = rsp_count;
        send(1'b0, 16'h0114, 8'h00);
        i_CMD_VALID = 1'b0;
        wait_rsp(r0 + 1);
        chk("edge_access_cycles", last_acc, 16);
        chk("edge_flag", last_tmo, 1'b0);
        chk("edge_rdata", last_rdata, 8'h5A);

        // Back-to-back writes with CMD_VALID held high
        waits = 0; r0 = rsp_count; n0 = acc_n;
        send(1'b1, 16'h0200, 8'h11);
        send(1'b1, 16'h0204, 8'h22);
        send(1'b1, 16'h0208, 8'h33);
        i_CMD_VALID = 1'b0;
        wait_rsp(r0 + 3);
        chk("b2b_rsp_count", rsp_count - r0, 3);
        chk("b2b_gap1", acc_times[(n0 + 1) % 16] - acc_times[n0 % 16], 3);
        chk("b2b_gap2", acc_times[(n0 + 2) % 16] - acc_times[(n0 + 1) % 16], 3);
        chk("b2b_last_pwdata", o_PWDATA, 8'h33);

        // Reset during the second wait cycle of ACCESS
        waits = 255; r0 = rsp_count; found = 1'b0;
        send(1'b0, 16'h0300, 8'h00);
        i_CMD_VALID = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_PSEL0 && o_PENABLE && acc_k == 1) begin found = 1'b1; break; end
        end
        chk("mid_access_reached", found, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_psel_low", o_PSEL0, 1'b0);
        chk("async_penable_low", o_PENABLE, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready_low", o_CMD_READY, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_one_edge", o_CMD_READY, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_no_rsp", rsp_count - r0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 16, maximum ACCESS-phase cycles with i_PREADY low before abort (range 2..255).
REQ-002 SHALL have ports:
- i_PCLK  in  1  sole clock, all state on rising edge.
- i_PRESET  in  1  asynchronous, active-high reset.
- i_CMD_VALID  in  1  command request.
- o_CMD_READY  out  1  command accepted when high with i_CMD_VALID.
- i_CMD_WRITE  in  1  1=write, 0=read.
- i_CMD_ADDR  in  16  target APB address.
- i_CMD_WDATA  in  8  write data.
- o_PSEL0  out  1  APB select.
- o_PENABLE  out  1  APB enable.
- o_PWRITE  out  1  APB direction.
- o_PADDR  out  16  APB address.
- o_PWDATA  out  8  APB write data.
- i_PRDATA  in  8  APB read data.
- i_PREADY  in  1  APB completer ready.
- o_RSP_VALID  out  1  one-cycle completion pulse.
- o_RSP_RDATA  out  8  read result.
- o_RSP_TIMEOUT  out  1  completion was a timeout abort, qualified by o_RSP_VALID.
REQ-003 SHALL register all outputs; no combinational input-to-output path.

Function
REQ-004 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-005 SHALL drive o_CMD_READY=1 only in IDLE.
REQ-006 SHALL accept a command on a rising edge with IDLE and i_CMD_VALID=1: capture ADDR/WRITE into o_PADDR/o_PWRITE, drive o_PWDATA=i_CMD_WDATA for writes and 8'h00 for reads, go to SETUP.
REQ-007 SHALL drive o_PSEL0=1, o_PENABLE=0 in SETUP, and go to ACCESS after exactly one cycle.
REQ-008 SHALL drive o_PSEL0=1, o_PENABLE=1 in ACCESS, holding o_PADDR/o_PWRITE/o_PWDATA stable until exit.
REQ-009 SHALL clear the 8-bit wait counter on SETUP entry and increment it on each ACCESS cycle with i_PREADY=0.
REQ-010 SHALL, on an edge in ACCESS with i_PREADY=1: return to IDLE, clear o_PSEL0/o_PENABLE, pulse o_RSP_VALID for one cycle with o_RSP_TIMEOUT=0, and set o_RSP_RDATA=i_PRDATA (read) or 8'h00 (write).
REQ-011 SHALL, on an edge in ACCESS with i_PREADY=0 and counter = TIMEOUT_CYCLES-1: abort to IDLE, clear o_PSEL0/o_PENABLE, pulse o_RSP_VALID with o_RSP_TIMEOUT=1 and o_RSP_RDATA=8'h00.
REQ-012 SHALL give i_PREADY=1 priority over timeout on the same edge.
REQ-013 SHALL ignore i_PREADY outside ACCESS.
REQ-014 SHALL hold o_RSP_RDATA and o_RSP_TIMEOUT until the next completion; o_PADDR/o_PWRITE/o_PWDATA hold last values in IDLE.
REQ-015 SHALL support back-to-back commands: o_CMD_READY=1 in the o_RSP_VALID cycle, minimum 3 cycles accept-to-accept with zero wait states.
REQ-016 SHALL leave i_CMD_VALID held high while not IDLE unconsumed; it is accepted on the next IDLE edge.

Reset
REQ-017 SHALL, while i_PRESET=1 (asynchronously, including mid-transfer): state=IDLE, counter=0, o_PSEL0=0, o_PENABLE=0, o_PWRITE=0, o_PADDR=16'h0000, o_PWDATA=8'h00, o_RSP_VALID=0, o_RSP_RDATA=8'h00, o_RSP_TIMEOUT=0, o_CMD_READY=0.
REQ-018 SHALL set o_CMD_READY=1 on the first rising edge after i_PRESET deasserts; no o_RSP_VALID for an aborted transfer.

Verification
REQ-019 Write, zero wait: cmd WRITE addr 16'h0104 data 8'hA5, i_PREADY=1 -> SETUP 1 cycle, ACCESS 1 cycle with PADDR=0104/PWDATA=A5/PWRITE=1, RSP_VALID pulse with TIMEOUT=0, RDATA=00.
REQ-020 Read, 3 wait states: cmd READ addr 16'h0108, PREADY low 3 ACCESS cycles then high with PRDATA=8'h3C -> 4 ACCESS cycles, PWDATA=00, RSP_RDATA=3C, TIMEOUT=0.
REQ-021 Timeout: TIMEOUT_CYCLES=16, PREADY held low -> exactly 16 ACCESS cycles, then PSEL0/PENABLE=0, RSP_VALID with TIMEOUT=1, RDATA=00; PREADY=1 in cycle 16 instead -> normal completion.
REQ-022 Back-to-back: CMD_VALID held high with 3 queued writes, PREADY=1 -> accepts 3 cycles apart, 3 RSP_VALID pulses, SETUP between every ACCESS.
REQ-023 Reset mid-ACCESS: assert i_PRESET in 2nd wait cycle -> PSEL0/PENABLE fall without clock edge, no RSP_VALID, CMD_READY=1 one edge after release.
